// File: rtl/cacheline_burst_adaptor.sv
// Cacheline adaptor: moves one full cache line per request as a burst of
// BUS_W-wide memory beats, serialising writes and assembling reads.
module cacheline_burst_adaptor #(
  parameter int LINE_W    = 256,
  parameter int BUS_W     = 32,
  parameter int ADDR_W    = 32,
  parameter int ADDR_INCR = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ca_address,
  input  logic              ca_read,
  input  logic              ca_write,
  input  logic [LINE_W-1:0] ca_wdata,
  output logic [LINE_W-1:0] ca_rdata,
  output logic              ca_resp,
  output logic              busy,
  output logic [ADDR_W-1:0] pmem_address,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [BUS_W-1:0]  pmem_wdata,
  input  logic [BUS_W-1:0]  pmem_rdata,
  input  logic              pmem_resp
);

  localparam int BEATS = LINE_W / BUS_W;
  localparam int CNT_W = $clog2(BEATS);
  localparam int OFF_W = $clog2(LINE_W / 8);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));
  localparam logic [ADDR_W-1:0] BEAT_BYTES = ADDR_W'(BUS_W / 8);
  localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(BEATS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]        state;
  logic [CNT_W-1:0]  beat;
  logic [ADDR_W-1:0] base;
  logic [LINE_W-1:0] wline;
  logic [LINE_W-1:0] rline;
  logic [ADDR_W-1:0] beat_offset;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register in this block samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      beat  <= '0;
      base  <= '0;
      rline <= '0;
    end else begin
      case (state)
        IDLE: begin
          beat <= '0;
          if (ca_read) begin
            state <= RD;
            base  <= ca_address & ALIGN_MASK;
          end else if (ca_write) begin
            state <= WR;
            base  <= ca_address & ALIGN_MASK;
          end
        end
        RD, WR: begin
          if (pmem_resp) begin
            if (state == RD) begin
              rline[beat*BUS_W +: BUS_W] <= pmem_rdata;
            end
            // BEATS is a power of two, so the last increment wraps back to 0.
            beat <= beat + 1'b1;
            if (beat == LAST_BEAT) begin
              state <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the write-line buffer is deliberately left without reset; it is
  // only observable through pmem_wdata, which is forced to zero outside WR.
  always_ff @(posedge clk) begin
    if (state == IDLE && !ca_read && ca_write) begin
      wline <= ca_wdata;
    end
  end

  assign beat_offset  = (ADDR_INCR != 0) ? ADDR_W'(beat) * BEAT_BYTES : '0;
  assign pmem_address = base + beat_offset;
  assign pmem_read    = (state == RD);
  assign pmem_write   = (state == WR);
  assign pmem_wdata   = (state == WR) ? wline[beat*BUS_W +: BUS_W] : '0;
  assign ca_resp      = (state == DONE);
  assign busy         = (state != IDLE);
  assign ca_rdata     = rline;

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Bench for cacheline_burst_adaptor: a transaction-level model checks the
// 256/32 instance every cycle; a 128/64 fixed-address instance is checked directly.
module tb_cacheline_burst_adaptor;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 256/32, incrementing address
  logic [31:0]  ca_address;
  logic         ca_read, ca_write;
  logic [255:0] ca_wdata, ca_rdata;
  logic         ca_resp, busy;
  logic [31:0]  pmem_address;
  logic         pmem_read, pmem_write;
  logic [31:0]  pmem_wdata, pmem_rdata;
  logic         pmem_resp;

  // 128/64, fixed address
  logic [31:0]  b_address;
  logic         b_read, b_write;
  logic [127:0] b_wdata, b_ca_rdata;
  logic         b_ca_resp, b_busy;
  logic [31:0]  b_pmem_address;
  logic         b_pmem_read, b_pmem_write;
  logic [63:0]  b_pmem_wdata, b_rdata;
  logic         b_resp;

  cacheline_burst_adaptor u_dut (
    .clk(clk), .rst(rst),
    .ca_address(ca_address), .ca_read(ca_read), .ca_write(ca_write),
    .ca_wdata(ca_wdata), .ca_rdata(ca_rdata), .ca_resp(ca_resp), .busy(busy),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  cacheline_burst_adaptor #(
    .LINE_W(128), .BUS_W(64), .ADDR_W(32), .ADDR_INCR(0)
  ) u_dut2 (
    .clk(clk), .rst(rst),
    .ca_address(b_address), .ca_read(b_read), .ca_write(b_write),
    .ca_wdata(b_wdata), .ca_rdata(b_ca_rdata), .ca_resp(b_ca_resp), .busy(b_busy),
    .pmem_address(b_pmem_address), .pmem_read(b_pmem_read), .pmem_write(b_pmem_write),
    .pmem_wdata(b_pmem_wdata), .pmem_rdata(b_rdata), .pmem_resp(b_resp)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Transaction-level model of the 256/32 instance: what burst is in flight,
  // which beat of it is outstanding, and the line contents it implies.
  typedef enum logic [1:0] {M_IDLE, M_READ, M_WRITE, M_DONE} mode_t;
  mode_t        m_mode;
  int           m_beat;
  logic [31:0]  m_base;
  logic [255:0] m_wline, m_rline;
  bit           chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_mode  <= M_IDLE;
      m_beat  <= 0;
      m_rline <= '0;
    end else begin
      case (m_mode)
        M_IDLE: if (ca_read || ca_write) begin
          m_base <= {ca_address[31:5], 5'b0};
          m_beat <= 0;
          if (ca_read) m_mode <= M_READ;
          else begin
            m_mode  <= M_WRITE;
            m_wline <= ca_wdata;
          end
        end
        M_READ, M_WRITE: if (pmem_resp) begin
          if (m_mode == M_READ) m_rline[m_beat*32 +: 32] <= pmem_rdata;
          if (m_beat == 7) m_mode <= M_DONE;
          else m_beat <= m_beat + 1;
        end
        M_DONE: begin
          m_mode <= M_IDLE;
          m_beat <= 0;
        end
        default: m_mode <= M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 256'(busy), 256'(m_mode != M_IDLE));
      check("ca_resp", 256'(ca_resp), 256'(m_mode == M_DONE));
      check("pmem_read", 256'(pmem_read), 256'(m_mode == M_READ));
      check("pmem_write", 256'(pmem_write), 256'(m_mode == M_WRITE));
      check("ca_rdata", ca_rdata, m_rline);
      if (m_mode == M_READ || m_mode == M_WRITE)
        check("pmem_address", 256'(pmem_address), 256'(m_base + 32'(m_beat) * 32'd4));
      if (m_mode == M_WRITE)
        check("pmem_wdata", 256'(pmem_wdata), 256'(m_wline[m_beat*32 +: 32]));
    end
  end

  // Runs the 256/32 burst that is already requested until ca_resp (bounded).
  // Request inputs are scrambled mid-burst to show they are not re-sampled.
  task automatic run1(input bit pattern, output int lat, output int nwr);
    int k = 0;
    bit done = 1'b0;
    lat = 0;
    nwr = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      lat++;
      if (pmem_write) nwr++;
      if (pmem_read) begin
        pmem_rdata = pattern ? 32'h11111111 * 32'(k + 1) : $urandom;
        k++;
      end
      if (lat == 3) begin
        ca_wdata   = ~ca_wdata;
        ca_address = ca_address ^ 32'h0000_0F00;
      end
      if (ca_resp) done = 1'b1;
    end
    check("ca_resp_seen", 256'(done), 256'(1));
  endtask

  // Runs a 128/64 burst already requested until ca_resp (bounded).
  task automatic dut2_run(input bit is_wr, input logic [127:0] w, input logic [127:0] r,
                          output int lat);
    int beat = 0;
    bit done = 1'b0;
    lat = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      lat++;
      if (b_pmem_read || b_pmem_write) begin
        check("b_pmem_address", 256'(b_pmem_address), 256'(32'h0000_2000));
        check("b_pmem_write", 256'(b_pmem_write), 256'(is_wr));
        if (beat < 2) begin
          if (is_wr) check("b_pmem_wdata", 256'(b_pmem_wdata), 256'(w[beat*64 +: 64]));
          else b_rdata = r[beat*64 +: 64];
        end
        beat++;
      end
      if (b_ca_resp) done = 1'b1;
    end
    check("b_ca_resp_seen", 256'(done), 256'(1));
    check("b_beats", 256'(beat), 256'(2));
  endtask

  initial begin
    int lat, nwr;
    logic [255:0] w1;
    logic [127:0] r1, w2, r3;

    rst = 1'b1;
    ca_address = '0; ca_read = 1'b0; ca_write = 1'b0; ca_wdata = '0;
    pmem_rdata = '0; pmem_resp = 1'b0;
    b_address = '0; b_read = 1'b0; b_write = 1'b0; b_wdata = '0;
    b_rdata = '0; b_resp = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_ca_resp", 256'(ca_resp), 256'(0));
    check("rst_pmem_read", 256'(pmem_read), 256'(0));
    check("rst_pmem_write", 256'(pmem_write), 256'(0));
    check("rst_pmem_address", 256'(pmem_address), 256'(0));
    check("rst_pmem_wdata", 256'(pmem_wdata), 256'(0));
    check("rst_ca_rdata", ca_rdata, 256'(0));
    rst = 1'b0;
    chk_en = 1'b1;

    // Read with a known beat pattern, pmem_resp every cycle.
    @(negedge clk);
    ca_address = 32'h0000_4A40; ca_read = 1'b1; pmem_resp = 1'b1;
    run1(1'b1, lat, nwr);
    check("rd_latency", 256'(lat), 256'(9));
    check("rd_line", ca_rdata,
          256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111);
    ca_read = 1'b0;
    @(negedge clk);
    check("rd_resp_one_cycle", 256'(ca_resp), 256'(0));

    // Write at an unaligned address with two stall cycles before every beat.
    w1 = rand_line();
    ca_address = 32'h0000_1013; ca_write = 1'b1; ca_wdata = w1; pmem_resp = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      for (int s = 0; s < 3; s++) begin
        check("wr_pmem_write", 256'(pmem_write), 256'(1));
        check("wr_address", 256'(pmem_address), 256'(32'h0000_1000 + 32'(k * 4)));
        check("wr_wdata", 256'(pmem_wdata), 256'(w1[k*32 +: 32]));
        pmem_resp = (s == 2);
        @(negedge clk);
      end
    end
    check("wr_ca_resp", 256'(ca_resp), 256'(1));
    ca_write = 1'b0; pmem_resp = 1'b1;
    @(negedge clk);
    check("wr_resp_one_cycle", 256'(ca_resp), 256'(0));
    check("wr_idle", 256'(busy), 256'(0));

    // Reset after three accepted read beats.
    ca_address = 32'h0000_8000; ca_read = 1'b1;
    repeat (3) begin
      @(negedge clk);
      pmem_rdata = $urandom;
    end
    @(negedge clk);
    rst = 1'b1; ca_read = 1'b0;
    @(negedge clk);
    check("abort_pmem_read", 256'(pmem_read), 256'(0));
    check("abort_busy", 256'(busy), 256'(0));
    check("abort_ca_rdata", ca_rdata, 256'(0));
    check("abort_ca_resp", 256'(ca_resp), 256'(0));
    rst = 1'b0;
    ca_address = 32'h0000_8040; ca_read = 1'b1;
    run1(1'b0, lat, nwr);
    check("after_abort_latency", 256'(lat), 256'(9));
    ca_read = 1'b0;
    @(negedge clk);

    // Read and write together: read wins; then a back-to-back write.
    ca_address = 32'h0000_C000; ca_read = 1'b1; ca_write = 1'b1; ca_wdata = rand_line();
    run1(1'b0, lat, nwr);
    check("rw_no_pmem_write", 256'(nwr), 256'(0));
    check("rw_latency", 256'(lat), 256'(9));
    ca_read = 1'b0; ca_wdata = rand_line();
    run1(1'b0, lat, nwr);
    check("b2b_write_latency", 256'(lat), 256'(10));
    check("b2b_write_beats", 256'(nwr), 256'(8));
    ca_write = 1'b0;

    // Spurious pmem_resp while idle, then a read must start at beat 0.
    repeat (4) begin
      @(negedge clk);
      check("spurious_idle_busy", 256'(busy), 256'(0));
    end
    ca_address = 32'h0000_051F; ca_read = 1'b1;
    @(negedge clk);
    check("spurious_first_addr", 256'(pmem_address), 256'(32'h0000_0500));
    run1(1'b0, lat, nwr);
    ca_read = 1'b0;

    // Randomised traffic: stalls, spurious responses, back-to-back, resets.
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      if (rst) rst = 1'b0;
      else if ($urandom_range(299) == 0) begin
        rst = 1'b1; ca_read = 1'b0; ca_write = 1'b0;
      end
      if (!rst) begin
        if (m_mode == M_DONE) begin
          if ($urandom_range(3) != 0) begin
            ca_read = 1'b0; ca_write = 1'b0;
          end
        end else if (!ca_read && !ca_write) begin
          if ($urandom_range(2) == 0) begin
            case ($urandom_range(2))
              0:       ca_read = 1'b1;
              1:       ca_write = 1'b1;
              default: begin ca_read = 1'b1; ca_write = 1'b1; end
            endcase
            ca_address = $urandom;
            ca_wdata   = rand_line();
          end
        end else if (m_mode != M_IDLE && $urandom_range(7) == 0) begin
          ca_address = $urandom;
          ca_wdata   = rand_line();
        end
      end
      pmem_resp  = ($urandom_range(2) != 0);
      pmem_rdata = $urandom;
    end
    @(negedge clk);
    rst = 1'b1; ca_read = 1'b0; ca_write = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // 128/64, fixed address: read, write then read back-to-back.
    r1 = {$urandom, $urandom, $urandom, $urandom};
    w2 = {$urandom, $urandom, $urandom, $urandom};
    r3 = {$urandom, $urandom, $urandom, $urandom};
    b_resp = 1'b1; b_address = 32'h0000_2000; b_read = 1'b1;
    dut2_run(1'b0, '0, r1, lat);
    check("b_rd_latency", 256'(lat), 256'(3));
    check("b_rd_line", 256'(b_ca_rdata), 256'(r1));
    b_read = 1'b0; b_write = 1'b1; b_wdata = w2;
    dut2_run(1'b1, w2, '0, lat);
    check("b_wr_latency", 256'(lat), 256'(4));
    check("b_rdata_kept", 256'(b_ca_rdata), 256'(r1));
    b_write = 1'b0; b_read = 1'b1;
    dut2_run(1'b0, '0, r3, lat);
    check("b_rd2_latency", 256'(lat), 256'(4));
    check("b_rd2_line", 256'(b_ca_rdata), 256'(r3));
    b_read = 1'b0;
    @(negedge clk);
    check("b_resp_one_cycle", 256'(b_ca_resp), 256'(0));
    check("b_idle", 256'(b_busy), 256'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
